ffe_channel_tx: RTL

Transmit-side stimulus source for the FFE receive path. Accepts PAM symbols over a valid/ready handshake and buffers them in a small FIFO. Each symbol is passed through a 3-tap ISI channel model (programmable taps), and the result is emitted on a signed data bus with a one-cycle load strobe at a programmable pacing. tx_data/tx_load connect directly to ffe_in_data/load_sig of the FFE.

---
 rtl/ffe_channel_tx_if.sv | 23 ++
 rtl/ffe_channel_tx.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ffe_channel_tx_if.sv
// ffe_channel_tx_if: symbol handshake and channel-output bus of ffe_channel_tx.
//   sym_in / sym_valid / sym_ready : symbol push handshake (valid/ready)
//   tx_data / tx_load              : channel output sample and its one-cycle strobe
// The "master" side is the symbol source and output observer. The "slave" side is the block.
interface ffe_channel_tx_if #(
    parameter int WIDTH = 12
);
    logic signed [WIDTH-1:0] sym_in;
    logic                    sym_valid;
    logic                    sym_ready;
    logic signed [WIDTH-1:0] tx_data;
    logic                    tx_load;

    modport master (
        output sym_in, sym_valid,
        input  sym_ready, tx_data, tx_load
    );

    modport slave (
        input  sym_in, sym_valid,
        output sym_ready, tx_data, tx_load
    );
endinterface

// File: rtl/ffe_channel_tx.sv
// ffe_channel_tx: transmit-side stimulus source for the FFE receive path.
// Buffers PAM symbols in a small FIFO. Each symbol passes through a 3-tap ISI
// channel model, y = h0*x[n] + h1*x[n-1] + h2*x[n-2], which is scaled by 2^-FRAC
// and saturated. The result is emitted on tx_data with a one-cycle tx_load strobe.
// After each strobe, cfg_gap idle cycles follow.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   bus        symbol handshake and output bus (slave side)
//   h0/h1/h2   signed taps Q(WIDTH-FRAC).FRAC, sampled at the pop edge
//   cfg_gap    idle cycles between strobes, sampled at the pop edge
//   tx_busy    high while pacing a gap or while symbols are queued
//   fifo_count current FIFO occupancy
module ffe_channel_tx #(
    parameter int WIDTH      = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAC       = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    ffe_channel_tx_if.slave               bus,
    input  logic signed [WIDTH-1:0]       h0,
    input  logic signed [WIDTH-1:0]       h1,
    input  logic signed [WIDTH-1:0]       h2,
    input  logic [3:0]                    cfg_gap,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = 2 * WIDTH;       // full product width
    localparam int SW = 2 * WIDTH + 2;   // three-product sum, no overflow possible

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, GAP} state_t;

    state_t                  state, state_next;
    logic [3:0]              gap_cnt, gap_next;
    logic signed [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic signed [WIDTH-1:0] hist1, hist2;   // x[n-1], x[n-2]
    logic                    push, pop;
    logic signed [WIDTH-1:0] head;
    logic signed [PW-1:0]    p0, p1, p2;
    logic signed [SW-1:0]    acc, acc_sh;
    logic signed [WIDTH-1:0] y_sat;

    // Readiness depends only on occupancy. A full FIFO refuses a push even when a pop happens in the same cycle.
    assign bus.sym_ready = (fifo_count < FULL_COUNT);
    assign push          = bus.sym_valid && bus.sym_ready;
    assign head          = mem[rd_ptr];
    assign tx_busy       = (state == GAP) || (fifo_count != '0);

    // Channel model on the FIFO head. The arithmetic shift floors toward -inf.
    always_comb begin
        p0     = PW'(h0) * PW'(head);
        p1     = PW'(h1) * PW'(hist1);
        p2     = PW'(h2) * PW'(hist2);
        acc    = SW'(p0) + SW'(p1) + SW'(p2);
        acc_sh = acc >>> FRAC;
        if (acc_sh > SAT_MAX)
            y_sat = SAT_MAX[WIDTH-1:0];
        else if (acc_sh < SAT_MIN)
            y_sat = SAT_MIN[WIDTH-1:0];
        else
            y_sat = acc_sh[WIDTH-1:0];
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop = 1'b1;
                    if (cfg_gap != 4'd0) begin
                        state_next = GAP;
                        gap_next   = cfg_gap;
                    end
                end
            end
            GAP: begin
                gap_next = gap_cnt - 4'd1;
                if (gap_cnt == 4'd1)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            hist1       <= '0;
            hist2       <= '0;
            bus.tx_data <= '0;
            bus.tx_load <= 1'b0;
        end else begin
            state       <= state_next;
            gap_cnt     <= gap_next;
            fifo_count  <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            bus.tx_load <= pop;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                bus.tx_data <= y_sat;
                hist2       <= hist1;
                hist1       <= head;
            end
        end
    end

    // NOTE: the storage array has no reset. Entries are only read after being written, because occupancy gates every pop.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.sym_in;
    end
endmodule
